vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 158 +++++++++++++++
 tb/tb_vram_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Three-port VRAM arbiter: video scan-out has priority, CPU drain and DMA
// share the leftover bandwidth round-robin, and a streak limit stops video
// from starving the low ports indefinitely. One memory transaction is in
// flight at a time. Every output is driven straight from a register.
module vram_arbiter #(
  parameter int MAX_STREAK = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_p0_request,
  input  logic        i_p0_rw,
  input  logic [31:0] i_p0_address,
  input  logic [31:0] i_p0_wdata,
  output logic [31:0] o_p0_rdata,
  output logic        o_p0_ready,
  input  logic        i_p1_request,
  input  logic        i_p1_rw,
  input  logic [31:0] i_p1_address,
  input  logic [31:0] i_p1_wdata,
  output logic [31:0] o_p1_rdata,
  output logic        o_p1_ready,
  input  logic        i_p2_request,
  input  logic        i_p2_rw,
  input  logic [31:0] i_p2_address,
  input  logic [31:0] i_p2_wdata,
  output logic [31:0] o_p2_rdata,
  output logic        o_p2_ready,
  output logic        o_mem_request,
  output logic        o_mem_rw,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ready,
  output logic [1:0]  o_grant,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] STREAK_MAX = 8'(MAX_STREAK);
  localparam logic [1:0] NO_GRANT   = 2'd3;

  state_t      state;
  logic [7:0]  streak;
  logic [1:0]  rr;
  logic        low_any;
  logic        force_low;
  logic [1:0]  win;
  logic        sel_rw;
  logic [31:0] sel_address;
  logic [31:0] sel_wdata;

  assign low_any   = i_p1_request | i_p2_request;
  assign force_low = low_any && (streak == STREAK_MAX);

  // Pick the winner among current requesters (only acted on in IDLE).
  always_comb begin
    win = NO_GRANT;
    if (i_p0_request && !force_low)         win = 2'd0;
    else if (i_p1_request && i_p2_request)  win = rr;
    else if (i_p1_request)                  win = 2'd1;
    else if (i_p2_request)                  win = 2'd2;
  end

  // Route the winner's command fields toward the memory-side latches.
  always_comb begin
    sel_rw      = 1'b0;
    sel_address = 32'd0;
    sel_wdata   = 32'd0;
    case (win)
      2'd0: begin sel_rw = i_p0_rw; sel_address = i_p0_address; sel_wdata = i_p0_wdata; end
      2'd1: begin sel_rw = i_p1_rw; sel_address = i_p1_address; sel_wdata = i_p1_wdata; end
      2'd2: begin sel_rw = i_p2_rw; sel_address = i_p2_address; sel_wdata = i_p2_wdata; end
      default: ;
    endcase
  end

  // Arbitration FSM; the o_mem_* registers double as the latched command.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state         <= IDLE;
      streak        <= 8'd0;
      rr            <= 2'd1;
      o_mem_request <= 1'b0;
      o_mem_rw      <= 1'b0;
      o_mem_address <= 32'd0;
      o_mem_wdata   <= 32'd0;
      o_p0_ready    <= 1'b0;
      o_p1_ready    <= 1'b0;
      o_p2_ready    <= 1'b0;
      o_p0_rdata    <= 32'd0;
      o_p1_rdata    <= 32'd0;
      o_p2_rdata    <= 32'd0;
      o_grant       <= NO_GRANT;
      o_busy        <= 1'b0;
    end else begin
      o_p0_ready <= 1'b0;
      o_p1_ready <= 1'b0;
      o_p2_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (win != NO_GRANT) begin
            state         <= ACCESS;
            o_mem_request <= 1'b1;
            o_mem_rw      <= sel_rw;
            o_mem_address <= sel_address;
            o_mem_wdata   <= sel_rw ? sel_wdata : 32'd0;
            o_grant       <= win;
            o_busy        <= 1'b1;
            if (win == 2'd0) begin
              if (!low_any)                  streak <= 8'd0;
              else if (streak < STREAK_MAX)  streak <= streak + 8'd1;
            end else begin
              streak <= 8'd0;
              rr     <= (win == 2'd1) ? 2'd2 : 2'd1;
            end
          end
        end
        ACCESS: begin
          if (i_mem_ready) begin
            state         <= RELEASE;
            o_mem_request <= 1'b0;
            o_mem_rw      <= 1'b0;
            o_mem_address <= 32'd0;
            o_mem_wdata   <= 32'd0;
            o_busy        <= 1'b0;
            o_p0_ready    <= (o_grant == 2'd0);
            o_p1_ready    <= (o_grant == 2'd1);
            o_p2_ready    <= (o_grant == 2'd2);
            if (!o_mem_rw) begin
              case (o_grant)
                2'd0:    o_p0_rdata <= i_mem_rdata;
                2'd1:    o_p1_rdata <= i_mem_rdata;
                2'd2:    o_p2_rdata <= i_mem_rdata;
                default: ;
              endcase
            end
          end
        end
        RELEASE: begin
          // Deliberately no arbitration here so a requester that drops one
          // cycle after its ready pulse is never granted a second time.
          state   <= IDLE;
          o_grant <= NO_GRANT;
        end
        default: begin
          state   <= IDLE;
          o_grant <= NO_GRANT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter. A transaction-level model tracks which
// port is on the memory bus and which port is in its completion cycle, and
// predicts every DUT output each cycle.
module tb_vram_arbiter;

  localparam int MAX_STREAK = 8;
  localparam int N_CYCLES   = 4000;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_p0_request, i_p0_rw, i_p1_request, i_p1_rw, i_p2_request, i_p2_rw;
  logic [31:0] i_p0_address, i_p0_wdata, i_p1_address, i_p1_wdata, i_p2_address, i_p2_wdata;
  logic [31:0] o_p0_rdata, o_p1_rdata, o_p2_rdata;
  logic        o_p0_ready, o_p1_ready, o_p2_ready;
  logic        o_mem_request, o_mem_rw;
  logic [31:0] o_mem_address, o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic        i_mem_ready;
  logic [1:0]  o_grant;
  logic        o_busy;

  vram_arbiter #(.MAX_STREAK(MAX_STREAK)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_p0_request(i_p0_request), .i_p0_rw(i_p0_rw), .i_p0_address(i_p0_address),
    .i_p0_wdata(i_p0_wdata), .o_p0_rdata(o_p0_rdata), .o_p0_ready(o_p0_ready),
    .i_p1_request(i_p1_request), .i_p1_rw(i_p1_rw), .i_p1_address(i_p1_address),
    .i_p1_wdata(i_p1_wdata), .o_p1_rdata(o_p1_rdata), .o_p1_ready(o_p1_ready),
    .i_p2_request(i_p2_request), .i_p2_rw(i_p2_rw), .i_p2_address(i_p2_address),
    .i_p2_wdata(i_p2_wdata), .o_p2_rdata(o_p2_rdata), .o_p2_ready(o_p2_ready),
    .o_mem_request(o_mem_request), .o_mem_rw(o_mem_rw), .o_mem_address(o_mem_address),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .o_grant(o_grant), .o_busy(o_busy)
  );

  always #5 i_clock = ~i_clock;

  int n_compared   = 0;
  int n_mismatched = 0;

  // bench-side requester state
  bit          b_req [3];
  bit          b_rw  [3];
  logic [31:0] b_addr[3];
  logic [31:0] b_wdata[3];
  bit          b_mem_ready;
  logic [31:0] b_mem_rdata;

  // reference model: port on the bus (act), port completing (rel), -1 = none
  int          act, rel, streak, rr;
  bit          m_rw;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata[3];
  int          grants[3];

  int p_raise[4][3] = '{'{30, 30, 30}, '{100, 50, 20}, '{0, 100, 100}, '{40, 40, 40}};
  int p_mem[4]      = '{60, 70, 50, 15};

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    act = -1; rel = -1; streak = 0; rr = 1;
    m_rw = 1'b0; m_addr = '0; m_wdata = '0;
    for (int n = 0; n < 3; n++) m_rdata[n] = '0;
  endtask

  // Effect of the coming rising edge, given the inputs now applied.
  task automatic model_step();
    int  win;
    bit  lo;
    if (act >= 0) begin
      if (b_mem_ready) begin
        if (!m_rw) m_rdata[act] = b_mem_rdata;
        rel = act;
        act = -1;
      end
    end else if (rel >= 0) begin
      rel = -1;
    end else begin
      lo  = b_req[1] || b_req[2];
      win = -1;
      if (b_req[0] && !(streak == MAX_STREAK && lo)) win = 0;
      else if (b_req[1] && b_req[2])                 win = rr;
      else if (b_req[1])                             win = 1;
      else if (b_req[2])                             win = 2;
      if (win >= 0) begin
        act     = win;
        m_rw    = b_rw[win];
        m_addr  = b_addr[win];
        m_wdata = b_rw[win] ? b_wdata[win] : 32'd0;
        grants[win]++;
        if (win == 0) streak = lo ? ((streak + 1 > MAX_STREAK) ? MAX_STREAK : streak + 1) : 0;
        else begin
          streak = 0;
          rr     = 3 - win;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [65:0] e_mem;
    logic [2:0]  e_rdy;
    logic [1:0]  e_gnt;
    e_mem = (act >= 0) ? {1'b1, m_rw, m_addr, m_wdata} : '0;
    e_rdy = 3'b000;
    if (rel >= 0) e_rdy[rel] = 1'b1;
    e_gnt = (act >= 0) ? act[1:0] : (rel >= 0) ? rel[1:0] : 2'd3;
    check_eq("mem_bus", {o_mem_request, o_mem_rw, o_mem_address, o_mem_wdata}, e_mem);
    check_eq("ready", {o_p2_ready, o_p1_ready, o_p0_ready}, e_rdy);
    check_eq("busy_grant", {o_busy, o_grant}, {(act >= 0), e_gnt});
    check_eq("p0_rdata", o_p0_rdata, m_rdata[0]);
    check_eq("p1_rdata", o_p1_rdata, m_rdata[1]);
    check_eq("p2_rdata", o_p2_rdata, m_rdata[2]);
  endtask

  task automatic drive_inputs(input int cyc);
    int ph;
    ph = cyc / 1000;
    for (int n = 0; n < 3; n++) begin
      if (rel == n)       b_req[n] = 1'b0;
      else if (!b_req[n]) b_req[n] = ($urandom_range(99) < p_raise[ph][n]);
      else if (ph == 0 && n != act && $urandom_range(99) < 5) b_req[n] = 1'b0;
      // command fields wander every cycle; only the value at grant matters
      b_rw[n]    = $urandom_range(1);
      b_addr[n]  = $urandom;
      b_wdata[n] = $urandom;
    end
    b_mem_ready = ($urandom_range(99) < p_mem[ph]);
    b_mem_rdata = $urandom;
    i_p0_request = b_req[0]; i_p0_rw = b_rw[0]; i_p0_address = b_addr[0]; i_p0_wdata = b_wdata[0];
    i_p1_request = b_req[1]; i_p1_rw = b_rw[1]; i_p1_address = b_addr[1]; i_p1_wdata = b_wdata[1];
    i_p2_request = b_req[2]; i_p2_rw = b_rw[2]; i_p2_address = b_addr[2]; i_p2_wdata = b_wdata[2];
    i_mem_ready  = b_mem_ready;
    i_mem_rdata  = b_mem_rdata;
  endtask

  initial begin
    int reset_cnt;
    int next_rst;
    reset_cnt = 0;
    next_rst  = 700;
    for (int n = 0; n < 3; n++) begin
      b_req[n] = 1'b0; b_rw[n] = 1'b0; b_addr[n] = '0; b_wdata[n] = '0; grants[n] = 0;
    end
    i_p0_request = 1'b0; i_p0_rw = 1'b0; i_p0_address = '0; i_p0_wdata = '0;
    i_p1_request = 1'b0; i_p1_rw = 1'b0; i_p1_address = '0; i_p1_wdata = '0;
    i_p2_request = 1'b0; i_p2_rw = 1'b0; i_p2_address = '0; i_p2_wdata = '0;
    i_mem_ready  = 1'b0; i_mem_rdata = '0;
    b_mem_ready  = 1'b0; b_mem_rdata = '0;
    model_reset();

    repeat (2) @(negedge i_clock);
    check_outputs();
    i_reset = 1'b0;

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge i_clock);
      check_outputs();
      if (reset_cnt > 0) begin
        reset_cnt--;
        if (reset_cnt == 0) i_reset = 1'b0;
      end
      drive_inputs(cyc);
      // asynchronous reset in the middle of a memory access
      if (!i_reset && cyc >= next_rst && act >= 0) begin
        i_reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        reset_cnt = 2;
        next_rst  = next_rst + 1400;
      end
      if (!i_reset) model_step();
    end

    $display("grants p0=%0d p1=%0d p2=%0d", grants[0], grants[1], grants[2]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
